// File: rtl/pipeline_pkg.sv
// Shared pipeline control types: sequencer states, register specifier width, NOP encoding.
package pipeline_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        HALT     = 2'd2,
        ERROR    = 2'd3
    } seqState_t;

    localparam int REG_ADDR_W = 5;

    // All-zero word decodes as a NOP for the IF/ID flush and ID/EX bubble consumers.
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard compare between the load in EX and the instruction in ID.
import pipeline_pkg::*;

module load_use_detect #(
    parameter int REG_ADDR_WIDTH = REG_ADDR_W
) (
    input  logic [REG_ADDR_WIDTH-1:0] idRs,
    input  logic [REG_ADDR_WIDTH-1:0] idRt,
    input  logic                      idUsesRt,
    input  logic                      idExMemRead,
    input  logic [REG_ADDR_WIDTH-1:0] idExRt,
    output logic                      loadUse
);

    // Register 0 is hardwired, so a load targeting it never hazards.
    assign loadUse = idExMemRead && (idExRt != '0) &&
                     ((idExRt == idRs) || (idUsesRt && (idExRt == idRt)));

endmodule

// File: rtl/hazard_sequencer.sv
// Arbitrated pipeline control: load-use stalls, branch flushes, memory waits with timeout, halt.
import pipeline_pkg::*;

module hazard_sequencer #(
    parameter int REG_ADDR_WIDTH = REG_ADDR_W,
    parameter int MEM_TIMEOUT    = 16,
    parameter int COUNT_WIDTH    = 16
) (
    input  logic                      clk,
    input  logic                      resetN,
    input  logic [REG_ADDR_WIDTH-1:0] idRs,
    input  logic [REG_ADDR_WIDTH-1:0] idRt,
    input  logic                      idUsesRt,
    input  logic                      idExMemRead,
    input  logic [REG_ADDR_WIDTH-1:0] idExRt,
    input  logic                      branchTaken,
    input  logic                      memReq,
    input  logic                      memReady,
    input  logic                      haltReq,
    output logic                      pcWrite,
    output logic                      ifIdWrite,
    output logic                      ifIdFlush,
    output logic                      idExBubble,
    output logic                      pipelineHold,
    output logic                      haltAck,
    output logic                      memError,
    output logic [COUNT_WIDTH-1:0]    stallCount,
    output logic [1:0]                state
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    seqState_t        curState, nextState;
    logic [WAIT_W-1:0] waitCnt, nextWait;
    logic             loadUse, setErr;

    load_use_detect #(.REG_ADDR_WIDTH(REG_ADDR_WIDTH)) uLoadUse (
        .idRs        (idRs),
        .idRt        (idRt),
        .idUsesRt    (idUsesRt),
        .idExMemRead (idExMemRead),
        .idExRt      (idExRt),
        .loadUse     (loadUse)
    );

    always_comb begin
        pcWrite      = 1'b1;
        ifIdWrite    = 1'b1;
        ifIdFlush    = 1'b0;
        idExBubble   = 1'b0;
        pipelineHold = 1'b0;
        haltAck      = 1'b0;
        setErr       = 1'b0;
        nextState    = curState;
        nextWait     = waitCnt;
        case (curState)
            RUN: begin
                if (memReq && !memReady) begin
                    pcWrite      = 1'b0;
                    ifIdWrite    = 1'b0;
                    pipelineHold = 1'b1;
                    nextState    = MEM_WAIT;
                    nextWait     = WAIT_W'(1);
                end else if (haltReq) begin
                    pcWrite      = 1'b0;
                    ifIdWrite    = 1'b0;
                    pipelineHold = 1'b1;
                    nextState    = HALT;
                end else if (loadUse) begin
                    // A same-cycle branch is dropped; it re-resolves once the load moves on.
                    pcWrite    = 1'b0;
                    ifIdWrite  = 1'b0;
                    idExBubble = 1'b1;
                end else if (branchTaken) begin
                    ifIdFlush = 1'b1;
                end
            end
            MEM_WAIT: begin
                if (memReady) begin
                    nextState = RUN;
                    nextWait  = '0;
                end else begin
                    pcWrite      = 1'b0;
                    ifIdWrite    = 1'b0;
                    pipelineHold = 1'b1;
                    // The cycle that would bring waitCnt to MEM_TIMEOUT is the timeout.
                    if (waitCnt >= WAIT_LAST) begin
                        nextState = ERROR;
                        nextWait  = '0;
                        setErr    = 1'b1;
                    end else begin
                        nextWait = waitCnt + WAIT_W'(1);
                    end
                end
            end
            HALT: begin
                pcWrite      = 1'b0;
                ifIdWrite    = 1'b0;
                pipelineHold = 1'b1;
                haltAck      = 1'b1;
                if (!haltReq) nextState = RUN;
            end
            ERROR: begin
                pcWrite      = 1'b0;
                ifIdWrite    = 1'b0;
                pipelineHold = 1'b1;
                haltAck      = 1'b1;
            end
            default: nextState = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            curState   <= RUN;
            waitCnt    <= '0;
            memError   <= 1'b0;
            stallCount <= '0;
        end else begin
            curState <= nextState;
            waitCnt  <= nextWait;
            if (setErr) memError <= 1'b1;
            if (!pcWrite && (stallCount != '1)) stallCount <= stallCount + COUNT_WIDTH'(1);
        end
    end

    assign state = curState;

endmodule

// File: tb/tb_hazard_sequencer.sv
// Directed bench for hazard_sequencer: per-cycle expected outputs queued on drive, checked at negedge.
module tb_hazard_sequencer;

    localparam int AW  = 5;
    localparam int TO  = 4;
    localparam int CW  = 4;
    localparam logic [CW-1:0] SAT = '1;

    logic          clk = 1'b0;
    logic          resetN;
    logic [AW-1:0] idRs, idRt, idExRt;
    logic          idUsesRt, idExMemRead, branchTaken, memReq, memReady, haltReq;
    logic          pcWrite, ifIdWrite, ifIdFlush, idExBubble, pipelineHold, haltAck, memError;
    logic [CW-1:0] stallCount;
    logic [1:0]    state;

    typedef struct {
        logic          pcW, ifW, flush, bub, hold, ack, err;
        logic [1:0]    st;
        logic [CW-1:0] stall;
    } exp_t;

    exp_t          sb[$];
    logic [CW-1:0] stallModel;
    int            passed = 0;
    int            total  = 0;

    hazard_sequencer #(.REG_ADDR_WIDTH(AW), .MEM_TIMEOUT(TO), .COUNT_WIDTH(CW)) dut (
        .clk(clk), .resetN(resetN),
        .idRs(idRs), .idRt(idRt), .idUsesRt(idUsesRt), .idExMemRead(idExMemRead),
        .idExRt(idExRt), .branchTaken(branchTaken), .memReq(memReq), .memReady(memReady),
        .haltReq(haltReq),
        .pcWrite(pcWrite), .ifIdWrite(ifIdWrite), .ifIdFlush(ifIdFlush),
        .idExBubble(idExBubble), .pipelineHold(pipelineHold), .haltAck(haltAck),
        .memError(memError), .stallCount(stallCount), .state(state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        total++;
        assert (obs === expv) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    endtask

    task automatic idle();
        idRs = '0; idRt = '0; idExRt = '0;
        idUsesRt = 0; idExMemRead = 0; branchTaken = 0;
        memReq = 0; memReady = 0; haltReq = 0;
    endtask

    // One clock: queue expectation for the current inputs, compare at negedge, advance.
    task automatic cyc(input string tag, input logic pcW, ifW, flush, bub, hold, ack, err,
                       input logic [1:0] st);
        exp_t e, got;
        e = '{pcW, ifW, flush, bub, hold, ack, err, st, stallModel};
        sb.push_back(e);
        @(negedge clk);
        total++;
        assert (sb.size() != 0) passed++;
        else $error("FAIL %s_sb: observed empty queue expected entry", tag);
        if (sb.size() != 0) begin
            got = sb.pop_front();
            chk({tag, "_pcWrite"}, 16'(pcWrite), 16'(got.pcW));
            chk({tag, "_ifIdWrite"}, 16'(ifIdWrite), 16'(got.ifW));
            chk({tag, "_ifIdFlush"}, 16'(ifIdFlush), 16'(got.flush));
            chk({tag, "_idExBubble"}, 16'(idExBubble), 16'(got.bub));
            chk({tag, "_pipelineHold"}, 16'(pipelineHold), 16'(got.hold));
            chk({tag, "_haltAck"}, 16'(haltAck), 16'(got.ack));
            chk({tag, "_memError"}, 16'(memError), 16'(got.err));
            chk({tag, "_state"}, 16'(state), 16'(got.st));
            chk({tag, "_stallCount"}, 16'(stallCount), 16'(got.stall));
            if (!got.pcW && stallModel != SAT) stallModel++;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle();
        resetN = 0;
        stallModel = '0;
        repeat (2) @(posedge clk);
        #1 resetN = 1;

        // idle RUN after reset
        cyc("rst", 1, 1, 0, 0, 0, 0, 0, 2'd0);

        // load-use on rs with a simultaneous branch: bubble wins, flush suppressed
        idExMemRead = 1; idExRt = 5; idRs = 5; branchTaken = 1;
        cyc("lu_rs", 0, 0, 0, 1, 0, 0, 0, 2'd0);
        idle();
        cyc("lu_after", 1, 1, 0, 0, 0, 0, 0, 2'd0);

        // r0 never hazards
        idExMemRead = 1; idExRt = 0; idRs = 0;
        cyc("lu_r0", 1, 1, 0, 0, 0, 0, 0, 2'd0);

        // rt match only counts when rt is read
        idle(); idExMemRead = 1; idExRt = 7; idRt = 7; idRs = 3;
        cyc("lu_rt_unused", 1, 1, 0, 0, 0, 0, 0, 2'd0);
        idUsesRt = 1;
        cyc("lu_rt_used", 0, 0, 0, 1, 0, 0, 0, 2'd0);

        // plain taken branch: flush for one cycle
        idle(); branchTaken = 1;
        cyc("br", 1, 1, 1, 0, 0, 0, 0, 2'd0);
        idle();
        cyc("br_after", 1, 1, 0, 0, 0, 0, 0, 2'd0);

        // 3-cycle memory wait then ready
        memReq = 1;
        cyc("mw0", 0, 0, 0, 0, 1, 0, 0, 2'd0);
        cyc("mw1", 0, 0, 0, 0, 1, 0, 0, 2'd1);
        cyc("mw2", 0, 0, 0, 0, 1, 0, 0, 2'd1);
        memReady = 1;
        cyc("mw_rdy", 1, 1, 0, 0, 0, 0, 0, 2'd1);
        idle();
        cyc("mw_done", 1, 1, 0, 0, 0, 0, 0, 2'd0);

        // halt during memory wait is deferred until ready
        memReq = 1;
        cyc("hmw0", 0, 0, 0, 0, 1, 0, 0, 2'd0);
        haltReq = 1;
        cyc("hmw1", 0, 0, 0, 0, 1, 0, 0, 2'd1);
        cyc("hmw2", 0, 0, 0, 0, 1, 0, 0, 2'd1);
        memReady = 1;
        cyc("hmw_rdy", 1, 1, 0, 0, 0, 0, 0, 2'd1);
        memReq = 0; memReady = 0;
        cyc("h_run", 0, 0, 0, 0, 1, 0, 0, 2'd0);
        cyc("h_halt", 0, 0, 0, 0, 1, 1, 0, 2'd2);
        haltReq = 0;
        cyc("h_rel", 0, 0, 0, 0, 1, 1, 0, 2'd2);
        cyc("h_resume", 1, 1, 0, 0, 0, 0, 0, 2'd0);

        // long halt drives stallCount into saturation
        haltReq = 1;
        cyc("sat_run", 0, 0, 0, 0, 1, 0, 0, 2'd0);
        for (int i = 0; i < 18; i++) cyc("sat", 0, 0, 0, 0, 1, 1, 0, 2'd2);
        haltReq = 0;
        cyc("sat_rel", 0, 0, 0, 0, 1, 1, 0, 2'd2);
        cyc("sat_run2", 1, 1, 0, 0, 0, 0, 0, 2'd0);

        // reset mid-run clears counters
        resetN = 0;
        #2 resetN = 1;
        stallModel = '0;
        cyc("rst2", 1, 1, 0, 0, 0, 0, 0, 2'd0);

        // timeout: 4 wait cycles then ERROR, sticky
        memReq = 1;
        cyc("to0", 0, 0, 0, 0, 1, 0, 0, 2'd0);
        cyc("to1", 0, 0, 0, 0, 1, 0, 0, 2'd1);
        cyc("to2", 0, 0, 0, 0, 1, 0, 0, 2'd1);
        cyc("to3", 0, 0, 0, 0, 1, 0, 0, 2'd1);
        cyc("err0", 0, 0, 0, 0, 1, 1, 1, 2'd3);
        memReady = 1; haltReq = 1;
        cyc("err_rdy", 0, 0, 0, 0, 1, 1, 1, 2'd3);
        idle();
        cyc("err_idle", 0, 0, 0, 0, 1, 1, 1, 2'd3);

        // reset pulse is the only way out of ERROR
        resetN = 0;
        #2 resetN = 1;
        stallModel = '0;
        cyc("err_rst", 1, 1, 0, 0, 0, 0, 0, 2'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
